pcoeff_result_collector: RTL and testbench
==========================================

Name: pcoeff_result_collector

Overview:
- Sits directly downstream of the 24-permute aggregating pipeline. Captures each per-batch result (resultValid, pcoeffSum, pcoeffCount) into a small register FIFO.
- Drives the pipeline's slowDown input with enough margin to absorb in-flight results.
- Presents the results to the host-side reader over a valid/ready handshake.
- Keeps running totals and sticky error flags for the host.

Parameters:
- PCOEFF_COUNT_BITWIDTH, 10, count width; sum width is PCOEFF_COUNT_BITWIDTH+35.
- DEPTH_LOG2, 5, FIFO depth = 2^DEPTH_LOG2 entries (32).
- ALMOST_FULL_MARGIN, 8, free entries still left when slowDown asserts; must cover pipeline slowDown response latency plus 1.
- TOTAL_BITWIDTH, 64, width of the running grand-total sum accumulator.

Ports:
- clk  in  1  single clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- resultValid  in  1  one result presented this cycle.
- pcoeffSum  in  PCOEFF_COUNT_BITWIDTH+35  per-batch sum.
- pcoeffCount  in  PCOEFF_COUNT_BITWIDTH  per-batch count.
- slowDown  out  1  registered backpressure to the pipeline.
- outValid  out  1  head entry available.
- outReady  in  1  reader accepts the head entry this cycle.
- outSum  out  PCOEFF_COUNT_BITWIDTH+35  head entry sum.
- outCount  out  PCOEFF_COUNT_BITWIDTH  head entry count.
- totalSum  out  TOTAL_BITWIDTH  running sum of all accepted pcoeffSum values.
- resultsAccepted  out  32  number of results written into the FIFO.
- overflowErr  out  1  sticky; a result was dropped.

Behaviour:
- Reset:
  - FIFO pointers and occupancy cleared.
  - Outputs: slowDown=0, outValid=0, outSum=0, outCount=0, totalSum=0, resultsAccepted=0, overflowErr=0.
  - Reset asserted mid-operation discards all buffered entries; a result presented during the rst cycle is ignored.
- Write:
  - Accept condition: resultValid && (occupancy < 2^DEPTH_LOG2 || (outValid && outReady)).
  - An accepted write stores {pcoeffSum, pcoeffCount} at the write pointer and advances it.
  - Pointers are DEPTH_LOG2 bits and wrap naturally; occupancy is a DEPTH_LOG2+1 bit counter.
- Write while full with no read in the same cycle:
  - The entry is dropped and overflowErr is set; it stays set until rst.
  - totalSum and resultsAccepted do not change.
- Read:
  - Show-ahead: outValid = occupancy != 0, registered.
  - outSum/outCount are registered copies of the head entry.
  - A handshake (outValid && outReady) pops the head. The next entry appears on the following cycle without a bubble.
  - outReady while outValid=0 is ignored.
- Latency: a write in cycle N into an empty FIFO gives outValid=1 with its data in cycle N+1.
- Simultaneous read and write:
  - Occupancy is unchanged; legal when full and when holding exactly 1 entry.
  - With 1 entry, the new entry becomes the head in the next cycle.
- slowDown: registered; slowDown <= (occupancy_next >= 2^DEPTH_LOG2 - ALMOST_FULL_MARGIN). Deasserts one cycle after occupancy drops below the threshold.
- Accumulators:
  - On each accepted write, totalSum += zero-extended pcoeffSum, wrapping modulo 2^TOTAL_BITWIDTH.
  - resultsAccepted += 1, wrapping modulo 2^32.
  - Both update in the cycle after the write.
- Stall: outReady held low is unbounded; the FIFO fills, slowDown holds, and no data is lost unless the upstream ignores slowDown.

Optional Feature:
- PCOEFF_RESULT_PARITY_EN defined:
  - Each FIFO entry stores one extra even-parity bit over {sum, count}, computed at write.
  - Parity is rechecked when the entry is loaded into the output registers.
  - A mismatch sets output port eccStatus (1 bit, sticky until rst); the data is still delivered.
- Not defined: no parity bit is stored and the eccStatus port is absent.

Decomposition:
- Shared package (pipelineGlobals header): PCOEFF_SUM_BITWIDTH = PCOEFF_COUNT_BITWIDTH+35, and a result-entry width constant (sum+count, +1 under the parity macro).
- One sub-module, result_register_fifo: a parameterised register-array FIFO with show-ahead output, occupancy, and full/empty.
- The collector wraps result_register_fifo with the slowDown, accumulator, overflow and parity logic.

Test Plan:
- Write sum=0x5, count=3 with outReady=1 -> outValid=1 next cycle with outSum=5 and outCount=3; totalSum=5 and resultsAccepted=1 one cycle after the write.
- outReady=0, write 24 results -> slowDown=1 the cycle after the 24th write (32-8); pop 1 -> slowDown=0 one cycle later.
- outReady=0, write 33 results -> 32 stored, overflowErr=1, resultsAccepted=32; then drain -> 32 results in order, values 1..32.
- FIFO full, resultValid and outReady asserted together -> no drop, occupancy stays 32, overflowErr=0.
- totalSum preloaded near wrap: results summing to 2^64+7 -> totalSum=7.
- With 10 entries buffered, assert rst mid-stream -> outValid=0, all counters 0 the next cycle; a post-reset write -> outValid=1 next cycle with the new value only.

Source files
------------

// File: rtl/pcoeff_result_collector_pkg.sv
// Shared widths for the pcoeff result path (pipelineGlobals header).
// Build option: PCOEFF_RESULT_PARITY_EN adds one even-parity bit to every stored entry.
package pcoeff_result_collector_pkg;

  localparam int unsigned PCOEFF_COUNT_BITWIDTH_DEFAULT = 10;
  localparam int unsigned PCOEFF_SUM_BITWIDTH = PCOEFF_COUNT_BITWIDTH_DEFAULT + 35;

`ifdef PCOEFF_RESULT_PARITY_EN
  localparam int unsigned RESULT_PARITY_BITS = 1;
`else
  localparam int unsigned RESULT_PARITY_BITS = 0;
`endif

  localparam int unsigned RESULT_ENTRY_BITWIDTH =
    PCOEFF_SUM_BITWIDTH + PCOEFF_COUNT_BITWIDTH_DEFAULT + RESULT_PARITY_BITS;

  // Sum width derived from a given count width.
  function automatic int unsigned sum_width(input int unsigned count_bw);
    return count_bw + 35;
  endfunction

  // Stored entry width: {parity?, sum, count}.
  function automatic int unsigned entry_width(input int unsigned count_bw);
    return sum_width(count_bw) + count_bw + RESULT_PARITY_BITS;
  endfunction

endpackage

// File: rtl/pcoeff_result_collector_fifo.sv
// result_register_fifo: register-array FIFO with registered show-ahead head,
// occupancy counter and full flag. out_valid doubles as the registered not-empty flag.
module result_register_fifo #(
  parameter int unsigned WIDTH      = 55,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [DEPTH_LOG2:0]   occupancy_next,
  output logic                  full,
  output logic                  wr_accept
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ONE_CNT   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  rd_accept;

  assign full      = (count_q == DEPTH_CNT);
  assign rd_accept = out_valid_q && rd_ready;
  assign wr_accept = wr_en && (!full || rd_accept);

  // Pointer/occupancy update and next head selection.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
    // The head is loaded from the input when the incoming entry becomes the
    // only one left (empty FIFO, or one entry popped in the same cycle).
    if (out_valid_d) begin
      if (wr_accept && (count_q == '0 || (count_q == ONE_CNT && rd_accept)))
        out_data_d = wr_data;
      else
        out_data_d = mem_q[rd_ptr_d];
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign occupancy_next = count_d;

endmodule

// File: rtl/pcoeff_result_collector.sv
// pcoeff_result_collector: buffers per-batch pipeline results, drives slowDown,
// keeps running totals and a sticky overflow flag.
// Build option: PCOEFF_RESULT_PARITY_EN adds per-entry parity and the eccStatus port.
module pcoeff_result_collector
  import pcoeff_result_collector_pkg::*;
#(
  parameter int unsigned PCOEFF_COUNT_BITWIDTH = PCOEFF_COUNT_BITWIDTH_DEFAULT,
  parameter int unsigned DEPTH_LOG2            = 5,
  parameter int unsigned ALMOST_FULL_MARGIN    = 8,
  parameter int unsigned TOTAL_BITWIDTH        = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                resultValid,
  input  logic [PCOEFF_COUNT_BITWIDTH+34:0]   pcoeffSum,
  input  logic [PCOEFF_COUNT_BITWIDTH-1:0]    pcoeffCount,
  output logic                                slowDown,
  output logic                                outValid,
  input  logic                                outReady,
  output logic [PCOEFF_COUNT_BITWIDTH+34:0]   outSum,
  output logic [PCOEFF_COUNT_BITWIDTH-1:0]    outCount,
  output logic [TOTAL_BITWIDTH-1:0]           totalSum,
  output logic [31:0]                         resultsAccepted,
`ifdef PCOEFF_RESULT_PARITY_EN
  output logic                                overflowErr,
  output logic                                eccStatus
`else
  output logic                                overflowErr
`endif
);

  localparam int unsigned SUM_W   = sum_width(PCOEFF_COUNT_BITWIDTH);
  localparam int unsigned ENTRY_W = entry_width(PCOEFF_COUNT_BITWIDTH);
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] SLOW_CNT = (DEPTH_LOG2+1)'(DEPTH - ALMOST_FULL_MARGIN);

  logic [ENTRY_W-1:0]        wr_entry, head_entry;
  logic                      fifo_out_valid, fifo_full, fifo_wr_accept;
  logic [DEPTH_LOG2:0]       fifo_occ_next;

  logic                      slow_q, slow_d;
  logic [TOTAL_BITWIDTH-1:0] total_q, total_d;
  logic [31:0]               accepted_q, accepted_d;
  logic                      overflow_q, overflow_d;

`ifdef PCOEFF_RESULT_PARITY_EN
  logic                      ecc_q, ecc_d;
  assign wr_entry = {^{pcoeffSum, pcoeffCount}, pcoeffSum, pcoeffCount};
`else
  assign wr_entry = {pcoeffSum, pcoeffCount};
`endif

  result_register_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (resultValid),
    .wr_data        (wr_entry),
    .rd_ready       (outReady),
    .out_valid      (fifo_out_valid),
    .out_data       (head_entry),
    .occupancy_next (fifo_occ_next),
    .full           (fifo_full),
    .wr_accept      (fifo_wr_accept)
  );

  // Backpressure, accumulators and sticky overflow.
  always_comb begin
    slow_d     = (fifo_occ_next >= SLOW_CNT);
    total_d    = total_q;
    accepted_d = accepted_q;
    overflow_d = overflow_q;
    if (fifo_wr_accept) begin
      total_d    = total_q + TOTAL_BITWIDTH'(pcoeffSum);
      accepted_d = accepted_q + 32'd1;
    end
    if (resultValid && fifo_full && !(fifo_out_valid && outReady))
      overflow_d = 1'b1;
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_q     <= 1'b0;
      total_q    <= '0;
      accepted_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      slow_q     <= slow_d;
      total_q    <= total_d;
      accepted_q <= accepted_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PCOEFF_RESULT_PARITY_EN
  // Parity over the registered head; any odd-weight head sets the sticky flag.
  always_comb begin
    ecc_d = ecc_q | (fifo_out_valid && (^head_entry));
  end

  // Sticky parity error register.
  always_ff @(posedge clk) begin
    if (rst) ecc_q <= 1'b0;
    else     ecc_q <= ecc_d;
  end

  assign eccStatus = ecc_q;
`endif

  assign slowDown        = slow_q;
  assign outValid        = fifo_out_valid;
  assign outSum          = head_entry[PCOEFF_COUNT_BITWIDTH +: SUM_W];
  assign outCount        = head_entry[PCOEFF_COUNT_BITWIDTH-1:0];
  assign totalSum        = total_q;
  assign resultsAccepted = accepted_q;
  assign overflowErr     = overflow_q;

endmodule

// File: tb/tb_pcoeff_result_collector.sv
// Scoreboard bench for pcoeff_result_collector: a queue model of the FIFO plus
// model totals; a second instance with a 48-bit accumulator exercises wrap.
module tb_pcoeff_result_collector;

  localparam int unsigned CW = 10;
  localparam int unsigned SW = CW + 35;

  logic          clk = 1'b0;
  logic          rst, resultValid, outReady;
  logic [SW-1:0] pcoeffSum;
  logic [CW-1:0] pcoeffCount;

  logic          slowDown, outValid, overflowErr;
  logic [SW-1:0] outSum;
  logic [CW-1:0] outCount;
  logic [63:0]   totalSum;
  logic [31:0]   resultsAccepted;

  logic          w_slowDown, w_outValid, w_overflowErr;
  logic [SW-1:0] w_outSum;
  logic [CW-1:0] w_outCount;
  logic [47:0]   w_totalSum;
  logic [31:0]   w_resultsAccepted;
`ifdef PCOEFF_RESULT_PARITY_EN
  logic          eccStatus, w_eccStatus;
`endif

  always #5 clk = ~clk;

  pcoeff_result_collector #(
    .PCOEFF_COUNT_BITWIDTH (CW),
    .DEPTH_LOG2            (5),
    .ALMOST_FULL_MARGIN    (8),
    .TOTAL_BITWIDTH        (64)
  ) u_dut (
    .clk (clk), .rst (rst), .resultValid (resultValid),
    .pcoeffSum (pcoeffSum), .pcoeffCount (pcoeffCount),
    .slowDown (slowDown), .outValid (outValid), .outReady (outReady),
    .outSum (outSum), .outCount (outCount), .totalSum (totalSum),
    .resultsAccepted (resultsAccepted),
`ifdef PCOEFF_RESULT_PARITY_EN
    .overflowErr (overflowErr), .eccStatus (eccStatus)
`else
    .overflowErr (overflowErr)
`endif
  );

  pcoeff_result_collector #(
    .PCOEFF_COUNT_BITWIDTH (CW),
    .DEPTH_LOG2            (5),
    .ALMOST_FULL_MARGIN    (8),
    .TOTAL_BITWIDTH        (48)
  ) u_dut_wrap (
    .clk (clk), .rst (rst), .resultValid (resultValid),
    .pcoeffSum (pcoeffSum), .pcoeffCount (pcoeffCount),
    .slowDown (w_slowDown), .outValid (w_outValid), .outReady (outReady),
    .outSum (w_outSum), .outCount (w_outCount), .totalSum (w_totalSum),
    .resultsAccepted (w_resultsAccepted),
`ifdef PCOEFF_RESULT_PARITY_EN
    .overflowErr (w_overflowErr), .eccStatus (w_eccStatus)
`else
    .overflowErr (w_overflowErr)
`endif
  );

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
  } entry_t;

  entry_t      sb[$];
  logic [63:0] m_total;
  logic [31:0] m_acc;
  logic        m_ovf;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status();
    check_eq("slow_down",        64'(slowDown),          64'(sb.size() >= 24));
    check_eq("total_sum",        totalSum,               m_total);
    check_eq("results_accepted", 64'(resultsAccepted),   64'(m_acc));
    check_eq("overflow_err",     64'(overflowErr),       64'(m_ovf));
    check_eq("w_slow_down",      64'(w_slowDown),        64'(sb.size() >= 24));
    check_eq("w_total_sum",      64'(w_totalSum),        64'(m_total[47:0]));
    check_eq("w_results_acc",    64'(w_resultsAccepted), 64'(m_acc));
    check_eq("w_overflow_err",   64'(w_overflowErr),     64'(m_ovf));
`ifdef PCOEFF_RESULT_PARITY_EN
    check_eq("ecc_status",       64'(eccStatus),         64'(0));
    check_eq("w_ecc_status",     64'(w_eccStatus),       64'(0));
`endif
  endtask

  // One clock cycle: drive inputs, check head against the scoreboard,
  // update the model, advance the clock, check registered status.
  task automatic cycle(input logic v, input logic [SW-1:0] s, input logic [CW-1:0] c,
                       input logic r);
    logic   pop, acc;
    entry_t e;
    resultValid = v;
    pcoeffSum   = s;
    pcoeffCount = c;
    outReady    = r;
    check_eq("out_valid",   64'(outValid),   64'(sb.size() != 0));
    check_eq("w_out_valid", 64'(w_outValid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check_eq("out_sum",     64'(outSum),     64'(sb[0].sum));
      check_eq("out_count",   64'(outCount),   64'(sb[0].cnt));
      check_eq("w_out_sum",   64'(w_outSum),   64'(sb[0].sum));
      check_eq("w_out_count", 64'(w_outCount), 64'(sb[0].cnt));
    end
    pop = (sb.size() != 0) && r;
    acc = v && ((sb.size() < 32) || pop);
    if (v && !acc) m_ovf = 1'b1;
    if (pop) e = sb.pop_front();
    if (acc) begin
      e.sum = s;
      e.cnt = c;
      sb.push_back(e);
      m_total = m_total + 64'(s);
      m_acc   = m_acc + 32'd1;
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  // Reset with a result presented during the reset cycle; it must be ignored.
  task automatic do_reset();
    rst         = 1'b1;
    resultValid = 1'b1;
    pcoeffSum   = SW'(45'h1F);
    pcoeffCount = CW'(10'h5);
    outReady    = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    resultValid = 1'b0;
    outReady    = 1'b0;
    sb.delete();
    m_total = '0;
    m_acc   = '0;
    m_ovf   = 1'b0;
    check_eq("rst_out_valid", 64'(outValid), 64'(0));
    check_eq("rst_out_sum",   64'(outSum),   64'(0));
    check_eq("rst_out_count", 64'(outCount), 64'(0));
    check_status();
  endtask

  initial begin
    rst = 1'b1; resultValid = 1'b0; outReady = 1'b0;
    pcoeffSum = '0; pcoeffCount = '0;
    m_total = '0; m_acc = '0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single result, 1-cycle latency, totals one cycle after the write.
    cycle(1'b1, SW'(5), CW'(3), 1'b1);
    check_eq("first_total",    totalSum,              64'd5);
    check_eq("first_accepted", 64'(resultsAccepted),  64'd1);
    check_eq("first_valid",    64'(outValid),         64'd1);
    check_eq("first_sum",      64'(outSum),           64'd5);
    check_eq("first_count",    64'(outCount),         64'd3);
    cycle(1'b0, '0, '0, 1'b1);

    // Simultaneous read/write with exactly one entry buffered.
    cycle(1'b1, SW'(11), CW'(1), 1'b0);
    cycle(1'b1, SW'(22), CW'(2), 1'b1);
    check_eq("one_entry_head", 64'(outSum), 64'd22);
    cycle(1'b0, '0, '0, 1'b1);

    // slowDown threshold at 24 entries, release after one pop.
    do_reset();
    for (int unsigned i = 1; i <= 24; i++) cycle(1'b1, SW'(i), CW'(i), 1'b0);
    check_eq("slow_at_24", 64'(slowDown), 64'd1);
    cycle(1'b0, '0, '0, 1'b1);
    check_eq("slow_release", 64'(slowDown), 64'd0);

    // Overflow: 33 writes with reader stalled, then drain in order.
    do_reset();
    for (int unsigned i = 1; i <= 33; i++) cycle(1'b1, SW'(i), CW'(i), 1'b0);
    check_eq("ovf_flag",     64'(overflowErr),     64'd1);
    check_eq("ovf_accepted", 64'(resultsAccepted), 64'd32);
    for (int unsigned i = 0; i < 33; i++) cycle(1'b0, '0, '0, 1'b1);
    check_eq("drained_valid", 64'(outValid), 64'd0);

    // Full FIFO with simultaneous write and read: nothing dropped.
    do_reset();
    for (int unsigned i = 1; i <= 32; i++) cycle(1'b1, SW'(i + 100), CW'(i), 1'b0);
    cycle(1'b1, SW'(500), CW'(9), 1'b1);
    check_eq("full_rw_ovf",  64'(overflowErr),     64'd0);
    check_eq("full_rw_acc",  64'(resultsAccepted), 64'd33);
    check_eq("full_rw_slow", 64'(slowDown),        64'd1);
    for (int unsigned i = 0; i < 33; i++) cycle(1'b0, '0, '0, 1'b1);

    // Accumulator wrap on the 48-bit instance: sums total 2^48 + 7.
    do_reset();
    for (int unsigned i = 0; i < 8; i++) cycle(1'b1, {SW{1'b1}}, CW'(1), 1'b1);
    cycle(1'b1, SW'(15), CW'(1), 1'b1);
    check_eq("wrap_total48", 64'(w_totalSum), 64'd7);
    check_eq("wrap_total64", totalSum,        64'h0001_0000_0000_0007);
    cycle(1'b0, '0, '0, 1'b1);

    // Reset mid-stream with 10 entries buffered, then a fresh write.
    do_reset();
    for (int unsigned i = 1; i <= 10; i++) cycle(1'b1, SW'(i * 3), CW'(i), 1'b0);
    do_reset();
    cycle(1'b1, SW'(45'h1234), CW'(10'h56), 1'b0);
    check_eq("post_rst_valid", 64'(outValid), 64'd1);
    check_eq("post_rst_sum",   64'(outSum),   64'h1234);
    cycle(1'b0, '0, '0, 1'b1);

    // Random traffic, upstream ignoring slowDown.
    do_reset();
    for (int unsigned i = 0; i < 400; i++) begin
      logic [63:0] r64;
      r64 = {$urandom(), $urandom()};
      cycle(($urandom_range(0, 9) < 7), r64[SW-1:0], CW'($urandom()),
            ($urandom_range(0, 9) < 4));
    end
    for (int unsigned i = 0; i < 33; i++) cycle(1'b0, '0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
